// File: rtl/sort_pkg.sv
// Shared definitions for the 8-entry exchange-sort controller: FSM states,
// memory geometry, and the per-state control word decode.
package sort_pkg;

    localparam int K      = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LOAD_A   = 4'd1,
        LOAD_B   = 4'd2,
        CMP      = 4'd3,
        SWAP_J   = 4'd4,
        SWAP_I   = 4'd5,
        RELOAD_A = 4'd6,
        NEXT_J   = 4'd7,
        NEXT_I   = 4'd8,
        DONE     = 4'd9
    } state_t;

    typedef struct packed {
        logic ea;
        logic eb;
        logic wr;
        logic lj;
        logic ei;
        logic ej;
        logic csel;
        logic bout;
        logic busy;
        logic done;
    } ctrl_t;

    function automatic state_t next_state(input state_t s, input logic start,
                                          input logic agtb, input logic zi,
                                          input logic zj);
        state_t n;
        n = IDLE;
        case (s)
            IDLE:     if (start) n = LOAD_A; else n = IDLE;
            LOAD_A:   n = LOAD_B;
            LOAD_B:   n = CMP;
            CMP:      if (agtb) n = SWAP_J; else n = NEXT_J;
            SWAP_J:   n = SWAP_I;
            SWAP_I:   n = RELOAD_A;
            RELOAD_A: n = NEXT_J;
            NEXT_J:   if (zj) n = NEXT_I; else n = LOAD_B;
            NEXT_I:   if (zi) n = DONE; else n = LOAD_A;
            DONE:     n = IDLE;
            default:  n = IDLE;
        endcase
        return n;
    endfunction

    // i and j are stable from CMP through NEXT_J/NEXT_I, so zi/zj sampled on
    // entry give the same pointer-step decision as sampling inside the state.
    function automatic ctrl_t ctrl_for(input state_t s, input logic zi, input logic zj);
        ctrl_t c;
        c = '0;
        case (s)
            IDLE: begin
                c = '0;
            end
            LOAD_A: begin
                c.ea   = 1'b1;
                c.lj   = 1'b1;
                c.busy = 1'b1;
            end
            LOAD_B: begin
                c.csel = 1'b1;
                c.eb   = 1'b1;
                c.busy = 1'b1;
            end
            CMP: begin
                c.busy = 1'b1;
            end
            SWAP_J: begin
                c.csel = 1'b1;
                c.wr   = 1'b1;
                c.busy = 1'b1;
            end
            SWAP_I: begin
                c.bout = 1'b1;
                c.wr   = 1'b1;
                c.busy = 1'b1;
            end
            RELOAD_A: begin
                c.ea   = 1'b1;
                c.busy = 1'b1;
            end
            NEXT_J: begin
                c.ej   = ~zj;
                c.busy = 1'b1;
            end
            NEXT_I: begin
                c.ei   = ~zi;
                c.busy = 1'b1;
            end
            DONE: begin
                c.done = 1'b1;
                c.busy = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sort_controller_if.sv
// Control/status bundle between the sort controller (master) and the
// pointer/register datapath plus RAM (slave).
interface sort_controller_if;

    logic start;
    logic AgtB;
    logic zi;
    logic zj;
    logic EA;
    logic EB;
    logic WR;
    logic Li;
    logic Lj;
    logic Ei;
    logic Ej;
    logic Csel;
    logic Bout;
    logic busy;
    logic done;

    modport master (
        input  start, AgtB, zi, zj,
        output EA, EB, WR, Li, Lj, Ei, Ej, Csel, Bout, busy, done
    );

    modport slave (
        output start, AgtB, zi, zj,
        input  EA, EB, WR, Li, Lj, Ei, Ej, Csel, Bout, busy, done
    );

endinterface

// File: rtl/sort_controller.sv
// Moore FSM sequencing an in-place exchange sort of an 8-entry memory through
// an external datapath; control outputs are registered alongside the state.
module sort_controller
    import sort_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    sort_controller_if.master bus
);

    state_t state_r;
    state_t state_next_s;
    ctrl_t  ctrl_r;

    assign state_next_s = next_state(state_r, bus.start, bus.AgtB, bus.zi, bus.zj);

    // FSM: advance the state and register the control word of the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ctrl_r  <= '0;
        end else begin
            state_r <= state_next_s;
            ctrl_r  <= ctrl_for(state_next_s, bus.zi, bus.zj);
        end
    end

    // i must be cleared on the same edge that accepts start, so Li follows start directly
    assign bus.Li   = (state_r == IDLE) & bus.start;
    assign bus.EA   = ctrl_r.ea;
    assign bus.EB   = ctrl_r.eb;
    assign bus.WR   = ctrl_r.wr;
    assign bus.Lj   = ctrl_r.lj;
    assign bus.Ei   = ctrl_r.ei;
    assign bus.Ej   = ctrl_r.ej;
    assign bus.Csel = ctrl_r.csel;
    assign bus.Bout = ctrl_r.bout;
    assign bus.busy = ctrl_r.busy;
    assign bus.done = ctrl_r.done;

endmodule
